// File: rtl/dll_pkg.sv
// rtl/dll_pkg.sv - shared constants, FSM state type and LCRC helper for the DLL receive path
package dll_pkg;

   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DATA  = 2'd1,
      S_DROP  = 2'd2,
      S_CHECK = 2'd3
   } state_t;

   // Reflected CRC-32 over one full 32-bit word, LSB (byte 0, bit 0) first.
   function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] data);
      logic [31:0] c;
      c = crc ^ data;
      for (int i = 0; i < 32; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/dll_rx_lcrc_ctrl_if.sv
// rtl/dll_rx_lcrc_ctrl_if.sv - upstream word stream, downstream TLP stream and ACK/NAK pulse bundle
interface dll_rx_lcrc_ctrl_if #(
   parameter int SEQ_W = 12
) ();

   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_data;
   logic             in_sop;
   logic             in_eop;

   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;
   logic             out_sop;
   logic             out_eop;

   logic             ack_valid;
   logic             ack_nak;
   logic [SEQ_W-1:0] ack_seq;

   // Environment side: deframer plus receive queue plus ACK scheduler.
   modport master (
      output in_valid, in_data, in_sop, in_eop, out_ready,
      input  in_ready, out_valid, out_data, out_sop, out_eop,
      input  ack_valid, ack_nak, ack_seq
   );

   // Controller side.
   modport slave (
      input  in_valid, in_data, in_sop, in_eop, out_ready,
      output in_ready, out_valid, out_data, out_sop, out_eop,
      output ack_valid, ack_nak, ack_seq
   );

endinterface

// File: rtl/dll_rx_buf.sv
// rtl/dll_rx_buf.sv - store-and-forward payload buffer with speculative write, commit and rollback
module dll_rx_buf #(
   parameter int DEPTH = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   input  logic        mark_eop,
   input  logic        commit,
   input  logic        rollback,
   input  logic        rd_ready,
   output logic        rd_valid,
   output logic [31:0] rd_data,
   output logic        rd_sop,
   output logic        rd_eop,
   output logic        full,
   output logic        has_payload,
   output logic        drained
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [31:0]    mem [DEPTH];
   logic [DEPTH-1:0] eop_bits;
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  commit_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_last;
   logic           first_flag;
   logic           rd_en;

   assign wr_last     = wr_ptr - PTR_ONE;
   assign rd_valid    = (rd_ptr != commit_ptr);
   assign rd_en       = rd_valid & rd_ready;
   assign rd_data     = rd_valid ? mem[rd_ptr[AW-1:0]] : 32'd0;
   assign rd_eop      = rd_valid & eop_bits[rd_ptr[AW-1:0]];
   assign rd_sop      = rd_valid & first_flag;
   assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign has_payload = (wr_ptr != commit_ptr);
   assign drained     = (commit_ptr == rd_ptr);

   // Storage: payload writes clear the eop flag; the eop word later tags the previous entry.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]]      <= wr_data;
         eop_bits[wr_ptr[AW-1:0]] <= 1'b0;
      end else if (mark_eop) begin
         eop_bits[wr_last[AW-1:0]] <= 1'b1;
      end
   end

   // Pointer bookkeeping; rollback discards everything written since the last commit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         commit_ptr <= '0;
         rd_ptr     <= '0;
         first_flag <= 1'b1;
      end else begin
         if (rollback)   wr_ptr <= commit_ptr;
         else if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (commit)     commit_ptr <= wr_ptr;
         if (rd_en) begin
            rd_ptr     <= rd_ptr + PTR_ONE;
            first_flag <= rd_eop;
         end
      end
   end

endmodule

// File: rtl/dll_rx_lcrc_ctrl.sv
// rtl/dll_rx_lcrc_ctrl.sv - receive DLL controller: LCRC/sequence check, commit/discard, ACK/NAK
module dll_rx_lcrc_ctrl
   import dll_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int SEQ_W = 12
) (
   input  logic               clk,
   input  logic               reset_n,
   dll_rx_lcrc_ctrl_if.slave  bus,
   output logic [15:0]        crc_err_cnt
);

   localparam logic [SEQ_W-1:0] SEQ_ONE = SEQ_W'(1);

   state_t           state;
   logic [31:0]      crc_reg;
   logic [SEQ_W-1:0] seq_reg;
   logic [SEQ_W-1:0] expected_seq;
   logic             fail_flag;
   logic             crc_ok;

   logic accept;
   logic wr_en;
   logic mark_eop;
   logic commit;
   logic rollback;
   logic full;
   logic has_payload;
   logic drained;

   // Upstream ready: the check cycle is the one bubble per packet; S_DATA stalls on full.
   always_comb begin
      bus.in_ready = 1'b0;
      case (state)
         S_IDLE:  bus.in_ready = 1'b1;
         S_DATA:  bus.in_ready = !full;
         S_DROP:  bus.in_ready = 1'b1;
         default: bus.in_ready = 1'b0;
      endcase
   end

   assign accept   = bus.in_valid & bus.in_ready;
   assign wr_en    = (state == S_DATA) && accept && !bus.in_eop;
   assign mark_eop = (state == S_DATA) && accept && bus.in_eop && has_payload;
   assign commit   = (state == S_CHECK) && !fail_flag && crc_ok && (seq_reg == expected_seq);
   assign rollback = (state == S_CHECK) && !commit;

   dll_rx_buf #(.DEPTH(DEPTH)) u_buf (
      .clk         (clk),
      .reset_n     (reset_n),
      .wr_en       (wr_en),
      .wr_data     (bus.in_data),
      .mark_eop    (mark_eop),
      .commit      (commit),
      .rollback    (rollback),
      .rd_ready    (bus.out_ready),
      .rd_valid    (bus.out_valid),
      .rd_data     (bus.out_data),
      .rd_sop      (bus.out_sop),
      .rd_eop      (bus.out_eop),
      .full        (full),
      .has_payload (has_payload),
      .drained     (drained)
   );

   // Packet FSM with registered ACK/NAK outputs and the LCRC accumulator.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         crc_reg       <= CRC32_INIT;
         seq_reg       <= '0;
         expected_seq  <= '0;
         fail_flag     <= 1'b0;
         crc_ok        <= 1'b0;
         crc_err_cnt   <= 16'd0;
         bus.ack_valid <= 1'b0;
         bus.ack_nak   <= 1'b0;
         bus.ack_seq   <= '0;
      end else begin
         bus.ack_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept && bus.in_sop) begin
                  seq_reg   <= bus.in_data[SEQ_W-1:0];
                  crc_reg   <= crc32_word(crc_reg, bus.in_data);
                  crc_ok    <= 1'b0;
                  fail_flag <= bus.in_eop;
                  state     <= bus.in_eop ? S_CHECK : S_DATA;
               end
            end
            S_DATA: begin
               if (accept) begin
                  if (!bus.in_eop) begin
                     crc_reg <= crc32_word(crc_reg, bus.in_data);
                  end else begin
                     crc_ok <= (~crc_reg == bus.in_data);
                     if (!has_payload) fail_flag <= 1'b1;
                     state <= S_CHECK;
                  end
               end else if (full && drained) begin
                  // Nothing left to read yet the buffer is full: the packet can never fit.
                  fail_flag <= 1'b1;
                  state     <= S_DROP;
               end
            end
            S_DROP: begin
               if (accept && bus.in_eop) state <= S_CHECK;
            end
            default: begin
               bus.ack_valid <= 1'b1;
               if (commit) begin
                  bus.ack_nak  <= 1'b0;
                  bus.ack_seq  <= seq_reg;
                  expected_seq <= expected_seq + SEQ_ONE;
               end else begin
                  bus.ack_nak <= fail_flag || !crc_ok;
                  bus.ack_seq <= expected_seq - SEQ_ONE;
               end
               if (!fail_flag && !crc_ok && (crc_err_cnt != 16'hFFFF)) begin
                  crc_err_cnt <= crc_err_cnt + 16'd1;
               end
               crc_reg <= CRC32_INIT;
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dll_rx_lcrc_ctrl.sv
// tb/tb_dll_rx_lcrc_ctrl.sv - scoreboard bench for the receive DLL LCRC controller
module tb_dll_rx_lcrc_ctrl;

   localparam int DEPTH = 8;
   localparam int SEQ_W = 12;

   typedef struct packed {
      logic [31:0] data;
      logic        sop;
      logic        eop;
   } out_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] crc_err_cnt;
   logic        toggle_en = 1'b0;
   logic        ready_level = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   out_t             exp_out[$];
   logic [SEQ_W:0]   exp_ack[$];

   dll_rx_lcrc_ctrl_if #(.SEQ_W(SEQ_W)) bus ();

   dll_rx_lcrc_ctrl #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (bus),
      .crc_err_cnt (crc_err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Independent bytewise bit-serial LCRC generator for building stimulus.
   function automatic logic [31:0] lcrc_of(input logic [31:0] w[$]);
      logic [31:0] c;
      logic [31:0] cur;
      logic        fb;
      c = 32'hFFFFFFFF;
      foreach (w[i]) begin
         cur = w[i];
         for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 8; k++) begin
               fb = c[0] ^ cur[8*b+k];
               c  = c >> 1;
               if (fb) c = c ^ 32'hEDB88320;
            end
         end
      end
      return ~c;
   endfunction

   // out_ready driver: fixed level or toggling every cycle.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (toggle_en) bus.out_ready = ~bus.out_ready;
         else           bus.out_ready = ready_level;
      end
   end

   // Monitor: pops expected words and ACKs whenever the DUT presents them.
   initial begin
      out_t           e;
      logic [SEQ_W:0] a;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (bus.out_valid && bus.out_ready) begin
               if (exp_out.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL out_unexpected: got data %0h sop %0b eop %0b, none required",
                           bus.out_data, bus.out_sop, bus.out_eop);
               end else begin
                  e = exp_out.pop_front();
                  check("out_word", {30'd0, bus.out_data, bus.out_sop, bus.out_eop}, {30'd0, e});
               end
            end
            if (bus.ack_valid) begin
               if (exp_ack.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL ack_unexpected: got nak %0b seq %0h, none required",
                           bus.ack_nak, bus.ack_seq);
               end else begin
                  a = exp_ack.pop_front();
                  check("ack", {51'd0, bus.ack_nak, bus.ack_seq}, {51'd0, a});
               end
            end
         end
      end
   end

   task automatic send_word(input logic [31:0] d, input logic s, input logic e, output int stalls);
      logic acc;
      acc = 1'b0;
      stalls = 0;
      bus.in_data  = d;
      bus.in_sop   = s;
      bus.in_eop   = e;
      bus.in_valid = 1'b1;
      for (int cyc = 0; cyc < 64 && !acc; cyc++) begin
         @(negedge clk);
         acc = bus.in_ready;
         if (!acc) stalls++;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      bus.in_sop   = 1'b0;
      bus.in_eop   = 1'b0;
      if (!acc) begin
         n_checks++;
         n_fail++;
         $display("FAIL in_ready_timeout: got in_ready 0 for 64 cycles, required 1");
      end
   endtask

   task automatic send_pkt(input logic [31:0] w[$], input logic [31:0] lcrc, output int stalls);
      int st;
      stalls = 0;
      foreach (w[i]) begin
         send_word(w[i], (i == 0), 1'b0, st);
         stalls += st;
      end
      send_word(lcrc, 1'b0, 1'b1, st);
      stalls += st;
   endtask

   task automatic expect_tlp(input logic [31:0] w[$]);
      for (int i = 1; i < w.size(); i++) begin
         exp_out.push_back('{data: w[i], sop: (i == 1), eop: (i == w.size() - 1)});
      end
   endtask

   task automatic expect_ack(input logic nak, input logic [SEQ_W-1:0] seq);
      exp_ack.push_back({nak, seq});
   endtask

   task automatic drain(input string name);
      int cyc;
      cyc = 0;
      while ((exp_out.size() != 0 || exp_ack.size() != 0) && cyc < 200) begin
         @(posedge clk);
         cyc++;
      end
      check({name, "_drained"}, {32'(exp_out.size()), 32'(exp_ack.size())}, 64'd0);
      exp_out.delete();
      exp_ack.delete();
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] p1[$];
      logic [31:0] p4[$];
      logic [31:0] pa[$];
      logic [31:0] pb[$];
      int          st;

      bus.in_valid = 1'b0;
      bus.in_data  = 32'd0;
      bus.in_sop   = 1'b0;
      bus.in_eop   = 1'b0;
      p1 = '{32'h0, 32'h0};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready",  bus.in_ready,  1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data",  bus.out_data,  0);
      check("rst_out_sopeop", {bus.out_sop, bus.out_eop}, 0);
      check("rst_ack",       {bus.ack_valid, bus.ack_nak, bus.ack_seq}, 0);
      check("rst_crc_err",   crc_err_cnt,   0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: minimal good packet
      expect_tlp(p1);
      expect_ack(1'b0, 12'h000);
      send_pkt(p1, 32'h6522DF69, st);
      drain("t1");

      // 2: bad LCRC, then the same seq is still expected
      do_reset();
      expect_ack(1'b1, 12'hFFF);
      send_pkt(p1, 32'h6522DF68, st);
      drain("t2");
      check("t2_crc_err_cnt", crc_err_cnt, 16'd1);
      expect_tlp(p1);
      expect_ack(1'b0, 12'h000);
      send_pkt(p1, 32'h6522DF69, st);
      drain("t2b");

      // 3: duplicate packet discarded, re-ACKed with last good seq
      do_reset();
      expect_tlp(p1);
      expect_ack(1'b0, 12'h000);
      send_pkt(p1, 32'h6522DF69, st);
      expect_ack(1'b0, 12'h000);
      send_pkt(p1, 32'h6522DF69, st);
      drain("t3");

      // 4: oversize packet dropped
      do_reset();
      ready_level = 1'b0;
      p4 = '{32'h0};
      for (int i = 1; i <= 10; i++) p4.push_back(32'h1000 + 32'(i));
      expect_ack(1'b1, 12'hFFF);
      send_pkt(p4, lcrc_of(p4), st);
      check("t4_stalls", st, 1);
      drain("t4");
      check("t4_out_valid", bus.out_valid, 0);
      check("t4_crc_err_cnt", crc_err_cnt, 16'd0);
      ready_level = 1'b1;

      // 5: back-to-back good packets with toggling out_ready
      do_reset();
      toggle_en = 1'b1;
      pa = '{32'h0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      pb = '{32'h1, 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
      expect_tlp(pa);
      expect_tlp(pb);
      expect_ack(1'b0, 12'h000);
      expect_ack(1'b0, 12'h001);
      send_pkt(pa, lcrc_of(pa), st);
      send_pkt(pb, lcrc_of(pb), st);
      drain("t5");
      toggle_en = 1'b0;

      // 6: reset in the middle of a packet
      do_reset();
      send_word(32'h0, 1'b1, 1'b0, st);
      send_word(32'h0, 1'b0, 1'b0, st);
      reset_n = 1'b0;
      @(negedge clk);
      check("t6_rst_outs", {bus.out_valid, bus.out_data, bus.ack_valid, crc_err_cnt}, 0);
      check("t6_rst_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("t6_buf_empty", bus.out_valid, 0);
      expect_tlp(p1);
      expect_ack(1'b0, 12'h000);
      send_pkt(p1, 32'h6522DF69, st);
      drain("t6");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, required completion");
      $fatal(1);
   end

endmodule
